// File: rtl/instruction_fetch_unit.sv
// instruction_fetch_unit
//   Fetches 16-bit instruction words from instruction memory and presents them,
//   in program order, to decode through a small FIFO. One memory request is
//   outstanding at a time. Redirects flush the queue and restart fetch. Halt only
//   blocks new requests.
//
// Ports
//   clk, reset_n                 clock, synchronous active-low reset
//   i_readM, i_address           memory read request / address (held until i_inputReady)
//   i_data, i_inputReady         memory read data / one-cycle completion strobe
//   if_valid, if_instr, if_pc    head of the fetch queue (registered)
//   id_ready                     decode pops the head when if_valid is high
//   redirect, redirect_pc        flush and refetch from redirect_pc
//   halt                         suppresses new requests while high
//   num_fetch, num_flush         perf counters (only with IF_PERF_CNT_EN)
//
// Configuration macro: IF_PERF_CNT_EN adds the saturating perf counters.

module instruction_fetch_unit #(
  parameter int unsigned WORD_SIZE   = 16,
  parameter int unsigned QUEUE_DEPTH = 2,
  parameter int unsigned RESET_PC    = 0
) (
  input  logic                 clk,
  input  logic                 reset_n,
  output logic                 i_readM,
  output logic [WORD_SIZE-1:0] i_address,
  input  logic [WORD_SIZE-1:0] i_data,
  input  logic                 i_inputReady,
  output logic                 if_valid,
  output logic [WORD_SIZE-1:0] if_instr,
  output logic [WORD_SIZE-1:0] if_pc,
  input  logic                 id_ready,
  input  logic                 redirect,
  input  logic [WORD_SIZE-1:0] redirect_pc,
`ifdef IF_PERF_CNT_EN
  output logic [15:0]          num_fetch,
  output logic [15:0]          num_flush,
`endif
  input  logic                 halt
);

  localparam int unsigned PTR_W = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(QUEUE_DEPTH) + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DROP = 2'd2
  } state_t;

  state_t               state, state_next;
  logic [WORD_SIZE-1:0] pc, pc_next;
  logic                 issue;
  logic                 push;

  logic [WORD_SIZE-1:0] q_instr [QUEUE_DEPTH];
  logic [WORD_SIZE-1:0] q_pc    [QUEUE_DEPTH];
  logic [PTR_W-1:0]     rd_ptr, rd_next;
  logic [PTR_W-1:0]     wr_ptr, wr_next;
  logic [CNT_W-1:0]     count, count_next, remain;
  logic                 pop;
  logic [WORD_SIZE-1:0] head_instr_next, head_pc_next;

  // State register
  always_ff @(posedge clk) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  // Next-state, pc and push decode.
  // Issue is only evaluated in IDLE where nothing is outstanding, so the
  // pending term of the occupancy test is zero there; the slot for an issued
  // request stays reserved because count can only fall until it returns.
  always_comb begin
    state_next = state;
    pc_next    = pc;
    issue      = 1'b0;
    push       = 1'b0;
    case (state)
      IDLE: begin
        if (!halt && !redirect && (count < CNT_W'(QUEUE_DEPTH))) begin
          state_next = REQ;
          issue      = 1'b1;
        end
      end
      REQ: begin
        if (i_inputReady) begin
          state_next = IDLE;
          if (!redirect) begin
            push    = 1'b1;
            pc_next = pc + WORD_SIZE'(1);
          end
        end else if (redirect) begin
          state_next = DROP;
        end
      end
      DROP: begin
        if (i_inputReady) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
    if (redirect) pc_next = redirect_pc;
  end

  // Queue bookkeeping; redirect overrides any same-cycle push or pop
  always_comb begin
    pop        = if_valid & id_ready & ~redirect;
    remain     = count - CNT_W'(pop);
    count_next = remain + CNT_W'(push);
    rd_next    = rd_ptr + PTR_W'(pop);
    wr_next    = wr_ptr + PTR_W'(push);
    if (redirect) begin
      count_next = '0;
      rd_next    = '0;
      wr_next    = '0;
    end
    // Head after this edge: the word being pushed if nothing else remains
    if (remain == '0) begin
      head_instr_next = i_data;
      head_pc_next    = pc;
    end else begin
      head_instr_next = q_instr[rd_next];
      head_pc_next    = q_pc[rd_next];
    end
  end

  // Queue storage (no reset needed; validity tracked by count)
  always_ff @(posedge clk) begin
    if (push) begin
      q_instr[wr_ptr] <= i_data;
      q_pc[wr_ptr]    <= pc;
    end
  end

  // Datapath and registered outputs
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      pc        <= WORD_SIZE'(RESET_PC);
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      count     <= '0;
      i_readM   <= 1'b0;
      i_address <= '0;
      if_valid  <= 1'b0;
      if_instr  <= '0;
      if_pc     <= '0;
    end else begin
      pc       <= pc_next;
      rd_ptr   <= rd_next;
      wr_ptr   <= wr_next;
      count    <= count_next;
      i_readM  <= (state_next != IDLE);
      if (issue) i_address <= pc;
      if_valid <= (count_next != '0);
      if (count_next != '0) begin
        if_instr <= head_instr_next;
        if_pc    <= head_pc_next;
      end
    end
  end

`ifdef IF_PERF_CNT_EN
  // Saturating perf counters, cleared only by reset
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      num_fetch <= '0;
      num_flush <= '0;
    end else begin
      if (push && (num_fetch != 16'hFFFF))     num_fetch <= num_fetch + 16'd1;
      if (redirect && (num_flush != 16'hFFFF)) num_flush <= num_flush + 16'd1;
    end
  end
`endif

endmodule
